master_i2c: RTL and testbench

Single-clock I2C bus master that runs one fixed three-byte transaction per `st` pulse:
- START
- `ADR_COM` (slave address + R/W)
- `adr_REG` (register address)
- `dat_REG` written, or one byte read into `RX_dat`
- STOP

It sits between the register/control logic and the open-drain SDA/SCL pins. It exports its internal strobes and counters for debug.

---
 rtl/master_i2c.sv | 197 +++++++++++++++++++
 tb/tb_master_i2c.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/master_i2c.sv
// Single-clock I2C master: START, three bytes (write, or optional read of byte 2), STOP.
// Optional read path is compiled in when MASTER_I2C_READ_EN is defined.
module master_i2c #(
  parameter int TACT_DIV = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       st,
  input  logic [7:0] ADR_COM,
  input  logic [7:0] adr_REG,
  input  logic [7:0] dat_REG,
  inout  wire        wireSDA,
  output logic       SCL,
  output logic       SDA_MASTER,
  output logic       T_start,
  output logic       T_stop,
  output logic       T_AC,
  output logic       en_tx,
  output logic       ce_tact,
  output logic       ce_bit,
  output logic       ce_byte,
  output logic       ce_AC,
  output logic       err_AC,
  output logic [3:0] cb_bit,
  output logic [2:0] cb_byte,
  output logic [7:0] sr_rx_SDA,
  output logic [7:0] RX_dat
);

  localparam int DW = (TACT_DIV > 1) ? $clog2(TACT_DIV) : 1;
  localparam logic [DW-1:0] TACT_MAX = DW'(TACT_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BYTE, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    tact_q, tact_d;
  logic [3:0]    cb_bit_q, cb_bit_d;
  logic [2:0]    cb_byte_q, cb_byte_d;
  logic          err_q, err_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    adr_q, adr_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    dat_q, dat_d;

  logic       busy, is_ack, rd_byte, sda_bit, sample;
  logic [7:0] tx_byte;

`ifdef MASTER_I2C_READ_EN
  assign rd_byte = adr_q[0] && (cb_byte_q == 3'd2);
`else
  assign rd_byte = 1'b0;
`endif

  assign busy    = (state_q != S_IDLE);
  assign ce_tact = busy && (div_q == '0);
  assign ce_bit  = ce_tact && (tact_q == 2'd3);
  assign is_ack  = (state_q == S_BYTE) && (cb_bit_q == 4'd8);
  assign ce_byte = ce_bit && is_ack;
  assign ce_AC   = ce_tact && (tact_q == 2'd2) && is_ack;
  assign sample  = ce_tact && (tact_q == 2'd2) && (state_q == S_BYTE) && !is_ack;

  // Anything other than a clean low (Z/X included) reads as 1, i.e. NACK.
  always_comb begin
    sda_bit = 1'b1;
    if (wireSDA == 1'b0) sda_bit = 1'b0;
  end

  always_comb begin
    case (cb_byte_q)
      3'd0:    tx_byte = adr_q;
      3'd1:    tx_byte = reg_q;
      default: tx_byte = dat_q;
    endcase
  end

  always_comb begin
    SCL        = 1'b1;
    SDA_MASTER = 1'b1;
    en_tx      = 1'b0;
    case (state_q)
      S_START: begin
        en_tx      = 1'b1;
        SDA_MASTER = (tact_q < 2'd2);
      end
      S_BYTE: begin
        SCL = (tact_q >= 2'd2);
        if (rd_byte) begin
          en_tx = is_ack;
        end else begin
          en_tx = !is_ack;
          if (!is_ack) SDA_MASTER = tx_byte[~cb_bit_q[2:0]];
        end
      end
      S_STOP: begin
        en_tx      = 1'b1;
        SCL        = (tact_q != 2'd0);
        SDA_MASTER = (tact_q >= 2'd2);
      end
      default: ;
    endcase
  end

  assign wireSDA = (en_tx && !SDA_MASTER) ? 1'b0 : 1'bz;

  always_comb begin
    state_d   = state_q;
    div_d     = busy ? ((div_q == '0) ? TACT_MAX : div_q - DW'(1)) : TACT_MAX;
    tact_d    = ce_tact ? tact_q + 2'd1 : tact_q;
    cb_bit_d  = cb_bit_q;
    cb_byte_d = cb_byte_q;
    err_d     = err_q;
    sr_d      = sr_q;
    rx_d      = rx_q;
    adr_d     = adr_q;
    reg_d     = reg_q;
    dat_d     = dat_q;
    case (state_q)
      S_IDLE: begin
        tact_d    = 2'd0;
        cb_bit_d  = 4'd0;
        cb_byte_d = 3'd0;
        if (st) begin
          state_d = S_START;
          adr_d   = ADR_COM;
          reg_d   = adr_REG;
          dat_d   = dat_REG;
          err_d   = 1'b0;
        end
      end
      S_START: begin
        if (ce_bit) state_d = S_BYTE;
      end
      S_BYTE: begin
        if (ce_AC && !rd_byte && sda_bit) err_d = 1'b1;
        if (sample && rd_byte) sr_d = {sr_q[6:0], sda_bit};
        if (ce_bit) begin
          if (is_ack) begin
            cb_bit_d = 4'd0;
            if (rd_byte) rx_d = sr_q;
            // err_q was set one tact earlier, so a NACK aborts straight to STOP.
            if (err_q || (cb_byte_q == 3'd2)) state_d = S_STOP;
            else cb_byte_d = cb_byte_q + 3'd1;
          end else begin
            cb_bit_d = cb_bit_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (ce_bit) begin
          state_d   = S_IDLE;
          cb_byte_d = 3'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= TACT_MAX;
      tact_q    <= 2'd0;
      cb_bit_q  <= 4'd0;
      cb_byte_q <= 3'd0;
      err_q     <= 1'b0;
      sr_q      <= 8'd0;
      rx_q      <= 8'd0;
      adr_q     <= 8'd0;
      reg_q     <= 8'd0;
      dat_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tact_q    <= tact_d;
      cb_bit_q  <= cb_bit_d;
      cb_byte_q <= cb_byte_d;
      err_q     <= err_d;
      sr_q      <= sr_d;
      rx_q      <= rx_d;
      adr_q     <= adr_d;
      reg_q     <= reg_d;
      dat_q     <= dat_d;
    end
  end

  assign T_start   = (state_q == S_START);
  assign T_stop    = (state_q == S_STOP);
  assign T_AC      = is_ack;
  assign err_AC    = err_q;
  assign cb_bit    = cb_bit_q;
  assign cb_byte   = cb_byte_q;
  assign sr_rx_SDA = sr_q;
  assign RX_dat    = rx_q;

endmodule

// File: tb/tb_master_i2c.sv
// Bench for master_i2c: a bit-timeline model of the transaction, checked against the DUT every cycle.
module tb_master_i2c;
  localparam int TD = 4;
  localparam int BITC = 4 * TD;
`ifdef MASTER_I2C_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st = 1'b0;
  logic [7:0] adr = 8'd0, regv = 8'd0, dat = 8'd0;
  logic slv_low = 1'b0;
  wire sda_bus;

  pullup (sda_bus);
  assign sda_bus = slv_low ? 1'b0 : 1'bz;

  logic SCL, SDA_MASTER, T_start, T_stop, T_AC, en_tx, ce_tact, ce_bit, ce_byte, ce_AC, err_AC;
  logic [3:0] cb_bit;
  logic [2:0] cb_byte;
  logic [7:0] sr_rx_SDA, RX_dat;

  master_i2c #(.TACT_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .st(st), .ADR_COM(adr), .adr_REG(regv), .dat_REG(dat),
    .wireSDA(sda_bus), .SCL(SCL), .SDA_MASTER(SDA_MASTER), .T_start(T_start), .T_stop(T_stop),
    .T_AC(T_AC), .en_tx(en_tx), .ce_tact(ce_tact), .ce_bit(ce_bit), .ce_byte(ce_byte),
    .ce_AC(ce_AC), .err_AC(err_AC), .cb_bit(cb_bit), .cb_byte(cb_byte),
    .sr_rx_SDA(sr_rx_SDA), .RX_dat(RX_dat)
  );

  always #5 clk = ~clk;

  // Per-bit description of the expected transaction (kind: 0 START, 1 data, 2 ACK, 3 STOP).
  int         d_kind[29];
  logic       d_sda[29], d_en[29], d_slow[29], d_nack[29], d_rx[29];
  logic [3:0] d_cbit[29];
  logic [2:0] d_cbyte[29];
  int         m_len = 0;
  logic [7:0] m_rx_val = 8'd0;

  logic       m_busy = 1'b0, m_err = 1'b0;
  int         m_k = 0;
  logic [7:0] m_rx = 8'd0;

  int n_assert = 0, n_fail = 0;
  int byte_tot = 0, tact_tot = 0;
  logic [23:0] bits_sh = 24'd0;
  logic [2:0] stop_cbyte = 3'd7;
  logic prev_stop = 1'b0;

  function automatic int bit_of(input int k);  return k / BITC; endfunction
  function automatic int tact_of(input int k); return (k / TD) % 4; endfunction
  function automatic logic ct_of(input int k); return (k % TD) == TD - 1; endfunction

  function automatic logic [25:0] expv(input logic busy, input int k, input logic e, input logic [7:0] rx);
    int b, t, kd;
    logic scl, sda, ct;
    if (!busy) return {2'b11, 8'd0, 4'd0, 3'd0, e, rx};
    b = bit_of(k); t = tact_of(k); ct = ct_of(k); kd = d_kind[b];
    case (kd)
      0:       begin scl = 1'b1;     sda = (t < 2);  end
      3:       begin scl = (t != 0); sda = (t >= 2); end
      default: begin scl = (t >= 2); sda = d_sda[b]; end
    endcase
    return {scl, sda, d_en[b], kd == 0, kd == 3, kd == 2, ct, ct && t == 3,
            kd == 2 && ct && t == 3, kd == 2 && ct && t == 2, d_cbit[b], d_cbyte[b], e, rx};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic put(inout int nb, input int kd, input logic sda, input logic en, input int cbit,
                     input int cby, input logic slow, input logic nack, input logic rx);
    d_kind[nb] = kd; d_sda[nb] = sda; d_en[nb] = en; d_cbit[nb] = 4'(cbit);
    d_cbyte[nb] = 3'(cby); d_slow[nb] = slow; d_nack[nb] = nack; d_rx[nb] = rx;
    nb++;
  endtask

  task automatic build(input logic [7:0] a, input logic [7:0] r, input logic [7:0] d,
                       input logic ack, input logic [7:0] sdat);
    int nb = 0, last = 0;
    logic done = 1'b0, isrd;
    logic [7:0] by;
    put(nb, 0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      if (!done) begin
        by = (j == 0) ? a : (j == 1) ? r : d;
        isrd = RD_EN && a[0] && (j == 2);
        for (int i = 0; i < 8; i++)
          put(nb, 1, isrd ? 1'b1 : by[7-i], !isrd, i, j, isrd ? !sdat[7-i] : 1'b0, 1'b0, 1'b0);
        put(nb, 2, 1'b1, isrd, 8, j, !isrd && ack, !isrd && !ack, isrd);
        last = j;
        if (!isrd && !ack) done = 1'b1;
      end
    end
    put(nb, 3, 1'b1, 1'b1, 0, last, 1'b0, 1'b0, 1'b0);
    m_len = nb * BITC;
    m_rx_val = sdat;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_k <= 0; m_err <= 1'b0; m_rx <= 8'd0;
    end else if (m_busy) begin
      if (d_kind[bit_of(m_k)] == 2 && ct_of(m_k)) begin
        if (tact_of(m_k) == 2 && d_nack[bit_of(m_k)]) m_err <= 1'b1;
        if (tact_of(m_k) == 3 && d_rx[bit_of(m_k)]) m_rx <= m_rx_val;
      end
      m_busy <= (m_k != m_len - 1);
      m_k <= m_k + 1;
    end else if (st) begin
      m_busy <= 1'b1; m_k <= 0; m_err <= 1'b0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 1000) begin @(negedge clk); n++; end
    chk("idle_timeout", {31'd0, m_busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] r, input logic [7:0] d,
                         input logic ack, input logic [7:0] sdat);
    build(a, r, d, ack, sdat);
    @(negedge clk);
    adr = a; regv = r; dat = d; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    wait_idle();
  endtask

  int b0, t0;

  initial begin
    fork
      forever begin
        @(negedge clk);
        chk("cycle", {6'd0, SCL, SDA_MASTER, en_tx, T_start, T_stop, T_AC, ce_tact, ce_bit,
                      ce_byte, ce_AC, cb_bit, cb_byte, err_AC, RX_dat},
            {6'd0, expv(m_busy, m_k, m_err, m_rx)});
        if (ce_byte) byte_tot++;
        if (ce_tact) tact_tot++;
        if (ce_tact && SCL && !ce_bit && !T_start && !T_stop && !T_AC) bits_sh = {bits_sh[22:0], sda_bus};
        if (T_stop && !prev_stop) stop_cbyte = cb_byte;
        prev_stop = T_stop;
        slv_low = m_busy && d_slow[bit_of(m_k)];
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_scl", {31'd0, SCL}, 32'd1);
    chk("rst_sda_master", {31'd0, SDA_MASTER}, 32'd1);
    chk("rst_outs", {16'd0, en_tx, T_start, T_stop, T_AC, ce_tact, err_AC, cb_bit, cb_byte, 3'd0}, 32'd0);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Plain write, slave ACKs every byte.
    b0 = byte_tot; t0 = tact_tot;
    run_txn(8'h70, 8'h70, 8'h70, 1'b1, 8'h00);
    chk("wr_bytes", byte_tot - b0, 32'd3);
    chk("wr_tacts", tact_tot - t0, 32'd116);
    chk("wr_bits", {8'd0, bits_sh}, 32'h707070);
    chk("wr_err", {31'd0, err_AC}, 32'd0);

    // No slave: first ACK reads high.
    b0 = byte_tot; t0 = tact_tot;
    run_txn(8'h50, 8'h12, 8'h34, 1'b0, 8'h00);
    chk("nack_err", {31'd0, err_AC}, 32'd1);
    chk("nack_bytes", byte_tot - b0, 32'd1);
    chk("nack_tacts", tact_tot - t0, 32'd44);
    chk("nack_stop_cbyte", {29'd0, stop_cbyte}, 32'd0);

    // Read (or plain write in the default build) of byte 2.
    run_txn(8'h71, 8'h0F, 8'h00, 1'b1, 8'hA5);
    chk("rd_err_cleared", {31'd0, err_AC}, 32'd0);
    chk("rd_rx_dat", {24'd0, RX_dat}, RD_EN ? 32'hA5 : 32'h00);
    chk("rd_sr", {24'd0, sr_rx_SDA}, RD_EN ? 32'hA5 : 32'h00);

    // st pulses mid-transfer and during STOP must be dropped.
    b0 = byte_tot;
    build(8'hA2, 8'h3C, 8'hC3, 1'b1, 8'h00);
    @(negedge clk);
    adr = 8'hA2; regv = 8'h3C; dat = 8'hC3; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (100) @(negedge clk);
    adr = 8'hFF; regv = 8'hFF; dat = 8'hFF; st = 1'b1;
    repeat (2) @(negedge clk);
    st = 1'b0;
    for (int n = 0; n < 1000 && m_busy && m_k < m_len - 6; n++) @(negedge clk);
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    wait_idle();
    chk("mid_st_bytes", byte_tot - b0, 32'd3);
    chk("mid_st_bits", {8'd0, bits_sh}, 32'hA23CC3);

    // Reset while the master is driving byte 1 low.
    build(8'h70, 8'h00, 8'h00, 1'b1, 8'h00);
    @(negedge clk);
    adr = 8'h70; regv = 8'h00; dat = 8'h00; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    for (int n = 0; n < 1000 && m_k < 180; n++) @(negedge clk);
    chk("pre_rst_sda_low", {31'd0, sda_bus}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_sda_released", {31'd0, sda_bus}, 32'd1);
    chk("rst_mid_outs", {24'd0, SCL, SDA_MASTER, en_tx, T_AC, cb_byte, 1'b0}, 32'hC0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    b0 = byte_tot;
    run_txn(8'h70, 8'h70, 8'h70, 1'b1, 8'h00);
    chk("post_rst_bytes", byte_tot - b0, 32'd3);
    chk("post_rst_bits", {8'd0, bits_sh}, 32'h707070);
    chk("post_rst_err", {31'd0, err_AC}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
